// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: FSM encodings, parity codes, baud divisor.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per bit period; truncating division matches the baud counter reload.
    function automatic int uart_cycle(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Brief    : Valid/ready byte handshake from a producer into the UART TX block.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready;

    modport master (output tx_data, output tx_data_valid, input  tx_data_ready);
    modport slave  (input  tx_data, input  tx_data_valid, output tx_data_ready);
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock show-ahead FIFO; the head word is always on rd_data.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       wr_en,
    input  wire logic [WIDTH-1:0]           wr_data,
    input  wire logic                       rd_en,
    output logic      [WIDTH-1:0]           rd_data,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     level
);
    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW-1:0]  c_ONE  = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_level == c_FULL);
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];
    // A write is judged against the pre-edge fullness, so a pop on the same edge does not help it.
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_ONE;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : FIFO-fed UART transmitter sending back-to-back frames while data waits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    uart_tx_if.slave                           bus,
    output logic                               tx_pin,
    output logic                               tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);
    localparam int          c_CYCLE    = uart_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [15:0] c_CYCLE_M1 = 16'(c_CYCLE - 1);
    localparam logic [2:0]  c_LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic        c_LAST_STP = 1'(STOP_BITS - 1);

    uart_state_e          r_state;
    logic [15:0]          r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_tx_pin;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic                 w_bit_done;
    logic                 w_last_stop;

    assign bus.tx_data_ready = !w_full && rst_n;
    assign w_wr_en     = bus.tx_data_valid && bus.tx_data_ready;
    assign w_bit_done  = (r_baud_cnt == c_CYCLE_M1);
    assign w_last_stop = (r_stop_cnt == c_LAST_STP);
    assign w_head_par  = (PARITY == PARITY_ODD) ? ~(^w_head) : (^w_head);
    assign w_rd_en     = !w_empty && ((r_state == ST_IDLE) ||
                         (r_state == ST_STOP && w_bit_done && w_last_stop));
    assign tx_pin      = r_tx_pin;
    assign tx_busy     = (r_state != ST_IDLE);

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data (bus.tx_data),
        .rd_en   (w_rd_en),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_tx_pin   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud_cnt <= '0;
                    r_tx_pin   <= 1'b1;
                    if (!w_empty) begin
                        r_shift   <= w_head;
                        r_par_bit <= w_head_par;
                        r_tx_pin  <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_tx_pin   <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_state    <= ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            if (PARITY != PARITY_NONE) begin
                                r_tx_pin <= r_par_bit;
                                r_state  <= ST_PARITY;
                            end else begin
                                r_tx_pin   <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= ST_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx_pin  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        r_tx_pin   <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= ST_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        if (!w_last_stop) begin
                            r_stop_cnt <= 1'b1;
                        end else if (!w_empty) begin
                            // Chain straight into the next start bit: no idle clock between frames.
                            r_shift   <= w_head;
                            r_par_bit <= w_head_par;
                            r_tx_pin  <= 1'b0;
                            r_state   <= ST_START;
                        end else begin
                            r_tx_pin <= 1'b1;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_baud_cnt <= '0;
                    r_tx_pin   <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
